// File: rtl/fetch_buffer.sv
// Three-wide fetch-to-dispatch instruction FIFO with a circular buffer of DEPTH entries.
// Define FETCH_BUFFER_BYPASS_EN to forward fetch packets straight to dispatch when the buffer is empty.
package fetch_buffer_pkg;
   typedef struct packed {
      logic        valid;
      logic [31:0] inst;
      logic [31:0] NPC;
      logic [31:0] PC;
   } IF_ID_PACKET;
endpackage

module fetch_buffer
   import fetch_buffer_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                       clock,
   input  logic                       reset,
   input  IF_ID_PACKET [2:0]          if_packet_in,
   input  logic [2:0]                 d_stall,
   input  logic                       squash,
   output logic [1:0]                 space_avail,
   output IF_ID_PACKET [2:0]          dis_packet_out,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       empty,
   output logic                       full
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   IF_ID_PACKET   mem_q [DEPTH];
   logic [PW-1:0] head_q, head_d, tail_q, tail_d;
   logic [CW-1:0] count_q, count_d, free;
   logic [1:0]    in_run, push_n, pop_n, wr_n, wr_off, rd_n;
   logic          bypass;

   assign free        = DEPTH_C - count_q;
   assign space_avail = (free >= CW'(3)) ? 2'd3 : free[1:0];
   assign count       = count_q;
   assign empty       = (count_q == '0);
   assign full        = (count_q == DEPTH_C);

`ifdef FETCH_BUFFER_BYPASS_EN
   assign bypass = (count_q == '0) && !squash;
`else
   assign bypass = 1'b0;
`endif

   // Only the contiguous valid run starting at slot 0 counts as fetched.
   always_comb begin
      in_run = 2'd0;
      if (if_packet_in[0].valid) begin
         in_run = 2'd1;
         if (if_packet_in[1].valid) begin
            in_run = 2'd2;
            if (if_packet_in[2].valid) in_run = 2'd3;
         end
      end
      push_n = (in_run > space_avail) ? space_avail : in_run;
   end

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         if (bypass) begin
            dis_packet_out[i]       = if_packet_in[i];
            dis_packet_out[i].valid = (2'(i) < push_n);
         end else begin
            dis_packet_out[i]       = mem_q[head_q + PW'(i)];
            dis_packet_out[i].valid = !squash && (CW'(i) < count_q);
         end
      end
   end

   always_comb begin
      pop_n = 2'd0;
      if (dis_packet_out[0].valid && !d_stall[0]) begin
         pop_n = 2'd1;
         if (dis_packet_out[1].valid && !d_stall[1]) begin
            pop_n = 2'd2;
            if (dis_packet_out[2].valid && !d_stall[2]) pop_n = 2'd3;
         end
      end
   end

   // In bypass the popped packets never touch storage; only the leftover tail is written.
   always_comb begin
      wr_off  = bypass ? pop_n : 2'd0;
      wr_n    = push_n - wr_off;
      rd_n    = bypass ? 2'd0 : pop_n;
      head_d  = head_q + PW'(rd_n);
      tail_d  = tail_q + PW'(wr_n);
      count_d = count_q + CW'(wr_n) - CW'(rd_n);
      if (squash) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Payload storage is deliberately not reset; pointers alone define occupancy.
   always_ff @(posedge clock) begin
      if (reset && !squash) begin
         for (int k = 0; k < 3; k++) begin
            if (2'(k) < wr_n) mem_q[tail_q + PW'(k)] <= if_packet_in[wr_off + 2'(k)];
         end
      end
   end
endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: queue-based reference model checked every cycle plus directed literal checks.
module tb_fetch_buffer;
   import fetch_buffer_pkg::*;

   localparam int DEPTH = 8;
`ifdef FETCH_BUFFER_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic              clock;
   logic              reset;
   IF_ID_PACKET [2:0] if_packet_in;
   logic [2:0]        d_stall;
   logic              squash;
   logic [1:0]        space_avail;
   IF_ID_PACKET [2:0] dis_packet_out;
   logic [3:0]        count;
   logic              empty;
   logic              full;

   int checks = 0;
   int errors = 0;

   fetch_buffer #(.DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset), .if_packet_in(if_packet_in), .d_stall(d_stall),
      .squash(squash), .space_avail(space_avail), .dis_packet_out(dis_packet_out),
      .count(count), .empty(empty), .full(full)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic IF_ID_PACKET mk(input logic v, input logic [31:0] pc);
      IF_ID_PACKET p;
      p.valid = v;
      p.PC    = pc;
      p.NPC   = pc + 32'd4;
      p.inst  = pc ^ 32'hA5A5_0013;
      return p;
   endfunction

   // Reference model: the buffer contents as an ordered queue of packets.
   IF_ID_PACKET mq[$];
   IF_ID_PACKET view [3];
   int          view_n;

   function automatic int accepted();
      int run = 0;
      int cap = DEPTH - mq.size();
      if (cap > 3) cap = 3;
      for (int i = 0; i < 3; i++) if (if_packet_in[i].valid && run == i) run++;
      return (run < cap) ? run : cap;
   endfunction

   function automatic void build_view();
      int acc = accepted();
      view_n = 0;
      if (BYP && mq.size() == 0 && !squash) begin
         for (int i = 0; i < acc; i++) view[i] = if_packet_in[i];
         view_n = acc;
      end else if (!squash) begin
         view_n = (mq.size() > 3) ? 3 : mq.size();
         for (int i = 0; i < view_n; i++) view[i] = mq[i];
      end
   endfunction

   function automatic int pops();
      int p = 0;
      for (int i = 0; i < 3; i++) if (i == p && i < view_n && !d_stall[i]) p++;
      return p;
   endfunction

   always @(negedge reset) mq.delete();

   always @(posedge clock) begin
      if (reset) begin
         int acc, p;
         bit byp;
         byp = BYP && mq.size() == 0 && !squash;
         acc = accepted();
         build_view();
         p = pops();
         if (squash) mq.delete();
         else if (byp) for (int i = p; i < acc; i++) mq.push_back(if_packet_in[i]);
         else begin
            repeat (p) void'(mq.pop_front());
            for (int i = 0; i < acc; i++) mq.push_back(if_packet_in[i]);
         end
      end
   end

   always @(negedge clock) begin
      if (reset) begin
         int sp;
         build_view();
         sp = DEPTH - mq.size();
         if (sp > 3) sp = 3;
         chk("m_count", 32'(count), 32'(mq.size()));
         chk("m_empty", 32'(empty), 32'(mq.size() == 0));
         chk("m_full",  32'(full),  32'(mq.size() == DEPTH));
         chk("m_space", 32'(space_avail), 32'(sp));
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("m_valid%0d", i), 32'(dis_packet_out[i].valid), 32'(i < view_n));
            if (i < view_n) begin
               chk($sformatf("m_pc%0d", i), dis_packet_out[i].PC, view[i].PC);
               chk($sformatf("m_inst%0d", i), dis_packet_out[i].inst, view[i].inst);
            end
         end
      end
   end

   task automatic put(input logic [2:0] v, input logic [31:0] base, input logic [2:0] st, input logic sq);
      for (int i = 0; i < 3; i++) if_packet_in[i] = mk(v[i], base + 32'(4 * i));
      d_stall = st;
      squash  = sq;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b0;
      put(3'b000, 32'h0, 3'b111, 1'b0);
      repeat (2) tick();
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_space", 32'(space_avail), 32'd3);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_valid", 32'({dis_packet_out[2].valid, dis_packet_out[1].valid, dis_packet_out[0].valid}), 32'd0);
      @(negedge clock); #1 reset = 1'b1;
      tick();

      put(3'b111, 32'h0, 3'b111, 1'b0); tick();
      put(3'b000, 32'h0, 3'b010, 1'b0); @(negedge clock);
      chk("fill3_count", 32'(count), 32'd3);
      chk("fill3_pc0", dis_packet_out[0].PC, 32'h0);
      chk("fill3_pc1", dis_packet_out[1].PC, 32'h4);
      chk("fill3_pc2", dis_packet_out[2].PC, 32'h8);
      chk("fill3_valid", 32'({dis_packet_out[2].valid, dis_packet_out[1].valid, dis_packet_out[0].valid}), 32'h7);
      tick();

      put(3'b111, 32'hC, 3'b111, 1'b0); @(negedge clock);
      chk("pop1_count", 32'(count), 32'd2);
      chk("pop1_pc0", dis_packet_out[0].PC, 32'h4);
      tick();
      put(3'b101, 32'h18, 3'b111, 1'b0); tick();
      put(3'b001, 32'h1C, 3'b111, 1'b0); tick();
      put(3'b111, 32'h20, 3'b111, 1'b0); @(negedge clock);
      chk("near_full_count", 32'(count), 32'd7);
      chk("near_full_space", 32'(space_avail), 32'd1);
      tick();
      put(3'b111, 32'h24, 3'b111, 1'b0); @(negedge clock);
      chk("full_flag", 32'(full), 32'd1);
      chk("full_space", 32'(space_avail), 32'd0);
      chk("full_count", 32'(count), 32'd8);
      tick();

      put(3'b000, 32'h0, 3'b000, 1'b0);
      repeat (3) tick();
      @(negedge clock);
      chk("drain_empty", 32'(empty), 32'd1);
      chk("drain_valid0", 32'(dis_packet_out[0].valid), 32'd0);
      tick();

      put(3'b111, 32'h100, 3'b111, 1'b0); tick();
      for (int k = 0; k < 20; k++) begin
         put(3'b111, 32'h10C + 32'(12 * k), 3'b000, 1'b0); @(negedge clock);
         chk($sformatf("stream%0d_count", k), 32'(count), 32'd3);
         chk($sformatf("stream%0d_pc0", k), dis_packet_out[0].PC, 32'h100 + 32'(12 * k));
         tick();
      end

      put(3'b011, 32'h1FC, 3'b111, 1'b0); @(negedge clock);
      chk("post_stream_pc0", dis_packet_out[0].PC, 32'h1F0);
      tick();
      put(3'b111, 32'h208, 3'b000, 1'b1); @(negedge clock);
      chk("squash_count_before", 32'(count), 32'd5);
      chk("squash_valid", 32'({dis_packet_out[2].valid, dis_packet_out[1].valid, dis_packet_out[0].valid}), 32'd0);
      tick();
      put(3'b000, 32'h0, 3'b111, 1'b0); @(negedge clock);
      chk("squash_count", 32'(count), 32'd0);
      chk("squash_empty", 32'(empty), 32'd1);
      tick();
      put(3'b111, 32'h300, 3'b111, 1'b0); tick();
      put(3'b000, 32'h0, 3'b111, 1'b0); @(negedge clock);
      chk("after_squash_pc0", dis_packet_out[0].PC, 32'h300);
      chk("after_squash_count", 32'(count), 32'd3);
      tick();

      put(3'b111, 32'h30C, 3'b111, 1'b0);
      #2 reset = 1'b0;
      #1;
      chk("async_rst_count", 32'(count), 32'd0);
      chk("async_rst_empty", 32'(empty), 32'd1);
      put(3'b000, 32'h0, 3'b111, 1'b0);
      @(negedge clock); #1 reset = 1'b1;
      tick();
      @(negedge clock);
      chk("after_rst_count", 32'(count), 32'd0);
      tick();

      put(3'b111, 32'h400, 3'b100, 1'b0); @(negedge clock);
`ifdef FETCH_BUFFER_BYPASS_EN
      chk("byp_valid0", 32'(dis_packet_out[0].valid), 32'd1);
      chk("byp_valid1", 32'(dis_packet_out[1].valid), 32'd1);
      chk("byp_pc0", dis_packet_out[0].PC, 32'h400);
      tick();
      put(3'b000, 32'h0, 3'b111, 1'b0); @(negedge clock);
      chk("byp_count", 32'(count), 32'd1);
      chk("byp_left_pc", dis_packet_out[0].PC, 32'h408);
`else
      chk("nobyp_valid0", 32'(dis_packet_out[0].valid), 32'd0);
      tick();
      put(3'b000, 32'h0, 3'b111, 1'b0); @(negedge clock);
      chk("nobyp_count", 32'(count), 32'd3);
      chk("nobyp_pc0", dis_packet_out[0].PC, 32'h400);
`endif
      tick();
      repeat (2) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of IF_ID_PACKET entries; power of 2, minimum 4.
REQ-002 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port if_packet_in  input  IF_ID_PACKET[2:0]  fetched instructions; slot 0 is oldest.
REQ-005 SHALL have port space_avail  output  2  entries fetch may send next cycle, equal to min(3, DEPTH-count).
REQ-006 SHALL have port dis_packet_out  output  IF_ID_PACKET[2:0]  oldest three entries to dispatch_stage; slot 0 is oldest.
REQ-007 SHALL have port d_stall  input  3  per-slot stall from dispatch_stage.
REQ-008 SHALL have port squash  input  1  flush, asserted on branch mispredict or precise-state recovery.
REQ-009 SHALL have port count  output  $clog2(DEPTH+1)  occupied entries.
REQ-010 SHALL have ports empty and full  output  1  each, where empty = (count==0) and full = (count==DEPTH).

Function
REQ-011 SHALL be a circular FIFO with head and tail pointers that wrap modulo DEPTH.
REQ-012 SHALL treat valid incoming packets as packed contiguously from slot 0; a valid slot after an invalid slot is ignored.
REQ-013 SHALL compute push_n as the number of leading valid if_packet_in slots, capped at space_avail; packets beyond the cap are dropped.
REQ-014 SHALL drive dis_packet_out[i] from entry head+i with valid=1 when i<count; otherwise valid=0 and the other fields are don't-care.
REQ-015 SHALL compute pop_n as the length of the leading run of slots with dis_packet_out[i].valid & ~d_stall[i]; the run stops at the first stalled or invalid slot.
REQ-016 SHALL advance head by pop_n and tail by push_n each cycle, with count_next = count + push_n - pop_n.
REQ-017 SHALL support simultaneous push and pop; space_avail uses the registered count only, ignoring same-cycle pops.
REQ-018 SHALL, when squash=1, set head=tail=0 and count=0 on the next edge, ignoring that cycle's push and pop.
REQ-019 SHALL force dis_packet_out valid bits to 0 during a squash cycle.
REQ-020 SHALL never overflow; a write when full is impossible by REQ-013.
REQ-021 SHALL have a minimum latency of 1 cycle from push to appearance on dis_packet_out, except as stated in REQ-026.

Reset
REQ-022 SHALL, while reset=0, asynchronously clear head, tail and count to 0.
REQ-023 SHALL, during reset, output empty=1, full=0, space_avail=3 and all dis_packet_out valid bits=0.
REQ-024 SHALL leave entry payload storage uncleared on reset; only pointers and count reset.
REQ-025 SHALL, on reset asserted mid-operation, discard all entries with no partial push.

Configuration
REQ-026 SHALL, with macro FETCH_BUFFER_BYPASS_EN defined and count==0 and squash==0, drive dis_packet_out combinationally from if_packet_in.
REQ-027 SHALL, in bypass mode, push only the packets not popped this cycle, i.e. push_n minus pop_n.
REQ-028 SHALL, without FETCH_BUFFER_BYPASS_EN, never bypass; an empty buffer shows all-invalid outputs.

Verification
REQ-029 Bench SHALL cover: after reset, push 3 valid packets (PC 0x0,0x4,0x8) with d_stall=3'b111 -> next cycle count=3, dis_packet_out PCs 0x0/0x4/0x8 valid.
REQ-030 Bench SHALL cover: count=3, d_stall=3'b010 -> pop_n=1, next cycle count=2, slot0 PC=0x4.
REQ-031 Bench SHALL cover: DEPTH=8, fill to 7 then push 3 -> space_avail=1 beforehand, only 1 accepted, full=1, space_avail=0.
REQ-032 Bench SHALL cover: 20 cycles of push 3 and pop 3 -> pointers wrap, PCs emerge in strict order, count constant.
REQ-033 Bench SHALL cover: count=5 with squash=1 plus a simultaneous push of 3 -> next cycle count=0, empty=1, no pushed packet retained.
REQ-034 Bench SHALL cover: with FETCH_BUFFER_BYPASS_EN, empty buffer, push 3, d_stall=3'b100 -> same-cycle slots 0-1 valid, pop_n=2, next cycle count=1 with PC=0x8.
